ex_muldiv_sequencer: RTL and testbench
======================================

// Module: ex_muldiv_sequencer
// PURPOSE
//  Iterative RV32M multiply/divide unit with its own sequencing FSM, sitting beside the EX-stage ALU.
//  EX hands off an M-extension op with a one-cycle Start pulse.
//  The block raises Stall_Pipeline to freeze IF/ID/EX while it iterates (one bit per cycle).
//  It returns a registered result with a one-cycle Done pulse, which MEM/WB captures.
// PARAMETERS
//  XLEN      32   operand/result width; iteration count = XLEN
// PORTS
//  clk             in   1     clock; all state updates on rising edge
//  rst             in   1     synchronous, active-high reset
//  Start_EX        in   1     one-cycle request; sampled only in IDLE
//  Funct3_EX       in   3     000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
//  Operand1_EX     in   XLEN  rs1 value (multiplicand / dividend), forwarded
//  Operand2_EX     in   XLEN  rs2 value (multiplier / divisor), forwarded
//  Flush_EX        in   1     branch/jump flush; aborts the op in flight
//  Busy            out  1     high in PREP, RUN and FIXUP
//  Stall_Pipeline  out  1     combinational: (Start_EX & IDLE & ~Flush_EX) | PREP | RUN
//  Done            out  1     one-cycle pulse; Result_Out valid in the same cycle
//  Result_Out      out  XLEN  registered result; holds its value until the next Done
// BEHAVIOUR
//  - Reset: state=IDLE, counter=0, Busy=0, Done=0, Result_Out=0, all internal regs 0.
//    Reset mid-operation discards the op; no Done is produced.
//  - FSM states: IDLE -> PREP -> RUN -> FIXUP -> IDLE.
//    - IDLE: on Start_EX & ~Flush_EX, latch Funct3 and operands, go to PREP.
//      Start_EX in any other state is ignored (no queueing).
//    - PREP (1 cycle):
//      - Compute operand magnitudes and result sign:
//        - signed operands: MULH (both), MULHSU (rs1 only), DIV/REM (both).
//        - MUL is sign-agnostic; treat as unsigned.
//      - Load counter = XLEN-1.
//      - Detect special cases for FIXUP: divisor==0; signed overflow (-2^(XLEN-1) / -1).
//    - RUN (XLEN cycles):
//      - Multiply: shift-add into a 2*XLEN product register.
//      - Divide: restoring, one quotient bit per cycle; remainder register is XLEN+1 bits.
//      - The counter decrements each cycle; leave RUN when counter==0.
//    - FIXUP (1 cycle):
//      - Apply sign correction and select the result.
//      - Write Result_Out and assert Done for this one cycle, then go to IDLE.
//      - Stall_Pipeline is low in this cycle so the pipeline advances.
//  - Latency: Start_EX high in cycle k -> Done high in cycle k+XLEN+2 (k+34 for XLEN=32).
//    A new Start_EX is accepted in cycle k+XLEN+3 at the earliest.
//  - Result selection:
//    - MUL: low XLEN bits of the product.
//    - MULH, MULHSU, MULHU: high XLEN bits of the (sign-corrected) 2*XLEN product.
//    - DIV/DIVU: quotient. REM/REMU: remainder; the remainder sign follows the dividend.
//    - Quotients truncate toward zero.
//  - Divide by zero: quotient = all ones (DIV and DIVU); remainder = dividend.
//  - Signed overflow: DIV result = -2^(XLEN-1); REM result = 0.
//    Special cases still take the full latency (fixed timing).
//  - Flush_EX:
//    - In PREP or RUN: next state is IDLE; Done stays 0; Result_Out is unchanged.
//    - In FIXUP: Done still fires; the pipeline discards it.
//    - In IDLE with Start_EX in the same cycle: flush wins, request dropped, Stall_Pipeline=0.
//  - Done is never asserted in two consecutive cycles.
// TESTING
//  - MUL 7 * 0xFFFFFFFD -> Result_Out=0xFFFFFFEB; Done exactly 34 cycles after Start;
//    Stall_Pipeline high for cycles 0-33 and low in the Done cycle.
//  - MULH 0x80000000*0x80000000 -> 0x40000000.
//    MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
//    MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
//  - DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
//  - DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0;
//    all with a 34-cycle latency.
//  - Start DIVU, assert Flush_EX on RUN cycle 10 -> Busy=0 next cycle, no Done, Result_Out unchanged;
//    a Start_EX on the following cycle is accepted and completes normally.
//  - Start_EX pulsed during RUN -> ignored; only one Done.
//    Assert rst mid-RUN -> all outputs 0 next cycle, no Done.

Source files
------------

// File: rtl/ex_muldiv_sequencer_if.sv
// ex_muldiv_sequencer_if: EX-stage handshake between the pipeline (master) and the multiply/divide unit (slave)
//  Start_EX/Funct3_EX/Operand1_EX/Operand2_EX/Flush_EX : pipeline -> unit request and abort
//  Busy/Stall_Pipeline/Done/Result_Out                  : unit -> pipeline status and result
interface ex_muldiv_sequencer_if #(parameter int XLEN = 32);
  logic            Start_EX;
  logic [2:0]      Funct3_EX;
  logic [XLEN-1:0] Operand1_EX;
  logic [XLEN-1:0] Operand2_EX;
  logic            Flush_EX;
  logic            Busy;
  logic            Stall_Pipeline;
  logic            Done;
  logic [XLEN-1:0] Result_Out;
  modport master (
    output Start_EX, Funct3_EX, Operand1_EX, Operand2_EX, Flush_EX,
    input  Busy, Stall_Pipeline, Done, Result_Out
  );
  modport slave (
    input  Start_EX, Funct3_EX, Operand1_EX, Operand2_EX, Flush_EX,
    output Busy, Stall_Pipeline, Done, Result_Out
  );
endinterface

// File: rtl/ex_muldiv_sequencer.sv
// ex_muldiv_sequencer: iterative RV32M multiply/divide unit, one bit per cycle, IDLE->PREP->RUN->FIXUP
//  clk, rst : clock and synchronous active-high reset
//  mdu      : slave side of ex_muldiv_sequencer_if (request, flush, stall, busy, done, result)
module ex_muldiv_sequencer #(parameter int XLEN = 32) (
  input logic clk,
  input logic rst,
  ex_muldiv_sequencer_if.slave mdu
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, PREP, RUN, FIXUP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] f3_q, f3_d;
  logic [XLEN-1:0] op1_q, op1_d, op2_q, op2_d, mcand_q, mcand_d, res_q, res_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [XLEN:0] rem_q, rem_d;
  logic neg_q, neg_d, divz_q, divz_d, ovf_q, ovf_d;
  logic accept, sa, sb, unused_rem_top;
  logic [XLEN-1:0] mag1, mag2, quo_nx, q_fix, r_fix, result_nx;
  logic [XLEN:0] mul_sum, shl, trial, rem_nx;
  logic [2*XLEN-1:0] step, prod_fix;
  assign accept = mdu.Start_EX & ~mdu.Flush_EX & (state_q == IDLE);
  assign sa = op1_q[XLEN-1] & (f3_q == 3'b001 | f3_q == 3'b010 | f3_q == 3'b100 | f3_q == 3'b110);
  assign sb = op2_q[XLEN-1] & (f3_q == 3'b001 | f3_q == 3'b100 | f3_q == 3'b110);
  assign mag1 = sa ? -op1_q : op1_q;
  assign mag2 = sb ? -op2_q : op2_q;
  // Multiply: product register holds {accumulator, remaining multiplier bits}, shifting right.
  assign mul_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, (prod_q[0] ? mcand_q : {XLEN{1'b0}})};
  // Divide: low half of the product register holds the dividend, shifted out MSB-first into the remainder
  // while quotient bits shift in at the bottom.
  assign shl = {rem_q[XLEN-1:0], prod_q[XLEN-1]};
  assign trial = shl - {1'b0, mcand_q};
  assign rem_nx = trial[XLEN] ? shl : trial;
  assign quo_nx = {prod_q[XLEN-2:0], ~trial[XLEN]};
  assign step = f3_q[2] ? {prod_q[2*XLEN-1:XLEN], quo_nx} : {mul_sum, prod_q[XLEN-1:1]};
  assign unused_rem_top = rem_q[XLEN];
  // Sign correction is applied to the values produced by the final iteration so the result
  // register is loaded on the RUN->FIXUP edge and is valid while Done is high.
  assign prod_fix = neg_q ? -step : step;
  assign q_fix = neg_q ? -quo_nx : quo_nx;
  assign r_fix = neg_q ? -rem_nx[XLEN-1:0] : rem_nx[XLEN-1:0];
  assign result_nx = !f3_q[2] ? (f3_q[1:0] == 2'b00 ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN]) :
                     divz_q ? (f3_q[1] ? op1_q : {XLEN{1'b1}}) :
                     ovf_q ? (f3_q[1] ? {XLEN{1'b0}} : MIN) :
                     f3_q[1] ? r_fix : q_fix;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    f3_d = f3_q;
    op1_d = op1_q;
    op2_d = op2_q;
    mcand_d = mcand_q;
    prod_d = prod_q;
    rem_d = rem_q;
    neg_d = neg_q;
    divz_d = divz_q;
    ovf_d = ovf_q;
    res_d = res_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = PREP;
        f3_d = mdu.Funct3_EX;
        op1_d = mdu.Operand1_EX;
        op2_d = mdu.Operand2_EX;
      end
      PREP: begin
        state_d = mdu.Flush_EX ? IDLE : RUN;
        cnt_d = CW'(XLEN-1);
        mcand_d = f3_q[2] ? mag2 : mag1;
        prod_d = {{XLEN{1'b0}}, (f3_q[2] ? mag1 : mag2)};
        rem_d = '0;
        neg_d = (f3_q[2] & f3_q[1]) ? sa : sa ^ sb;
        divz_d = f3_q[2] & (op2_q == '0);
        ovf_d = f3_q[2] & ~f3_q[0] & (op1_q == MIN) & (op2_q == '1);
      end
      RUN: begin
        state_d = mdu.Flush_EX ? IDLE : (cnt_q == '0) ? FIXUP : RUN;
        cnt_d = cnt_q - 1'b1;
        prod_d = step;
        rem_d = f3_q[2] ? rem_nx : rem_q;
        res_d = (cnt_q == '0 && !mdu.Flush_EX) ? result_nx : res_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      f3_q <= '0;
      op1_q <= '0;
      op2_q <= '0;
      mcand_q <= '0;
      prod_q <= '0;
      rem_q <= '0;
      neg_q <= 1'b0;
      divz_q <= 1'b0;
      ovf_q <= 1'b0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      f3_q <= f3_d;
      op1_q <= op1_d;
      op2_q <= op2_d;
      mcand_q <= mcand_d;
      prod_q <= prod_d;
      rem_q <= rem_d;
      neg_q <= neg_d;
      divz_q <= divz_d;
      ovf_q <= ovf_d;
      res_q <= res_d;
    end
  end
  assign mdu.Busy = state_q != IDLE;
  assign mdu.Stall_Pipeline = accept | (state_q == PREP) | (state_q == RUN);
  assign mdu.Done = state_q == FIXUP;
  assign mdu.Result_Out = res_q;
endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// tb_ex_muldiv_sequencer: scoreboard bench for the iterative multiply/divide unit
module tb_ex_muldiv_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  int start_q[$];
  logic [31:0] last_exp = '0;
  logic prev_done = 1'b0;
  ex_muldiv_sequencer_if #(.XLEN(32)) m();
  ex_muldiv_sequencer #(.XLEN(32)) dut (.clk(clk), .rst(rst), .mdu(m.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (m.Done === 1'b1) begin
      chk("done_gap", {31'b0, prev_done}, 32'd0);
      if (exp_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        chk("result", m.Result_Out, exp_q.pop_front());
        chk("latency", cyc - start_q.pop_front(), 32'd34);
      end
    end
    prev_done <= m.Done;
  end
  task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    m.Start_EX = 1'b1;
    m.Funct3_EX = f;
    m.Operand1_EX = a;
    m.Operand2_EX = b;
  endtask
  task automatic kick(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    drive(f, a, b);
    @(negedge clk);
    m.Start_EX = 1'b0;
  endtask
  task automatic wait_done();
    for (int i = 0; i < 45 && m.Done !== 1'b1; i++) @(negedge clk);
    chk("done_timeout", {31'b0, m.Done}, 32'd1);
  endtask
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    int st = 0;
    exp_q.push_back(e);
    start_q.push_back(cyc);
    drive(f, a, b);
    #1;
    for (int i = 0; i < 45; i++) begin
      if (m.Done === 1'b1) break;
      st += int'(m.Stall_Pipeline);
      @(negedge clk);
      m.Start_EX = 1'b0;
      #1;
    end
    chk("done_seen", {31'b0, m.Done}, 32'd1);
    chk("stall_at_done", {31'b0, m.Stall_Pipeline}, 32'd0);
    chk("stall_cycles", st, 32'd34);
    last_exp = e;
    @(negedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    m.Start_EX = 1'b0;
    m.Flush_EX = 1'b0;
    m.Funct3_EX = '0;
    m.Operand1_EX = '0;
    m.Operand2_EX = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, m.Busy}, 32'd0);
    chk("rst_done", {31'b0, m.Done}, 32'd0);
    chk("rst_result", m.Result_Out, 32'd0);
    chk("rst_stall", {31'b0, m.Stall_Pipeline}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run_op(3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB);
    run_op(3'b001, 32'h80000000, 32'h80000000, 32'h40000000);
    run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op(3'b010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF);
    run_op(3'b001, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF);
    run_op(3'b000, 32'h00012345, 32'h00010000, 32'h23450000);
    run_op(3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
    run_op(3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
    run_op(3'b101, 32'd100, 32'd7, 32'd14);
    run_op(3'b111, 32'd100, 32'd7, 32'd2);
    run_op(3'b100, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD);
    run_op(3'b110, 32'd7, 32'hFFFFFFFE, 32'd1);
    run_op(3'b100, 32'd5, 32'd0, 32'hFFFFFFFF);
    run_op(3'b110, 32'd5, 32'd0, 32'd5);
    run_op(3'b101, 32'd5, 32'd0, 32'hFFFFFFFF);
    run_op(3'b111, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9);
    run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0);
    // flush in RUN cycle 10
    kick(3'b101, 32'd1000, 32'd3);
    repeat (11) @(negedge clk);
    m.Flush_EX = 1'b1;
    @(negedge clk);
    m.Flush_EX = 1'b0;
    #1;
    chk("flush_busy", {31'b0, m.Busy}, 32'd0);
    chk("flush_result", m.Result_Out, last_exp);
    run_op(3'b101, 32'd1000, 32'd10, 32'd100);
    // flush and start together in IDLE
    drive(3'b000, 32'd3, 32'd3);
    m.Flush_EX = 1'b1;
    #1;
    chk("flush_idle_stall", {31'b0, m.Stall_Pipeline}, 32'd0);
    @(negedge clk);
    m.Start_EX = 1'b0;
    m.Flush_EX = 1'b0;
    #1;
    chk("flush_idle_busy", {31'b0, m.Busy}, 32'd0);
    @(negedge clk);
    // start during RUN is ignored
    exp_q.push_back(32'd42);
    start_q.push_back(cyc);
    kick(3'b000, 32'd6, 32'd7);
    repeat (5) @(negedge clk);
    kick(3'b000, 32'd3, 32'd3);
    wait_done();
    last_exp = 32'd42;
    repeat (40) @(negedge clk);
    // reset mid-RUN
    kick(3'b100, 32'd50, 32'd5);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_busy", {31'b0, m.Busy}, 32'd0);
    chk("midrst_done", {31'b0, m.Done}, 32'd0);
    chk("midrst_result", m.Result_Out, 32'd0);
    chk("midrst_stall", {31'b0, m.Stall_Pipeline}, 32'd0);
    repeat (40) @(negedge clk);
    chk("sb_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
